// File: rtl/mul_pkg.sv
// mul_pkg: shared state type and sizing constants for the sequential multiplier
package mul_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
    localparam int MUL_ITERS = 32;
    localparam int MUL_W = 32;
endpackage

// File: rtl/ripple_adder32.sv
// ripple_adder32: 32-bit ripple-carry adder
module ripple_adder32 (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);
    logic [32:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign S[i] = X[i] ^ Y[i] ^ c[i];
        assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
    end
    assign Cout = c[32];
endmodule

// File: rtl/seq_multiplier32.sv
// seq_multiplier32: unsigned 32x32->64 shift-and-add multiplier sequenced over one ripple adder
module seq_multiplier32
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] P
);
    mul_state_t state, state_n;
    logic [MUL_W-1:0] m, hi, lo, s;
    logic cout, accept, last;
    logic [5:0] cnt;
    ripple_adder32 u_add (.X(hi), .Y(m), .Cin(1'b0), .S(s), .Cout(cout));
    assign accept = start && state != RUN;
    assign last = state == RUN && cnt == 6'(MUL_ITERS - 1);
    always_comb begin
        state_n = accept ? RUN : state == DONE ? IDLE : last ? DONE : state;
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            m <= '0;
            hi <= '0;
            lo <= '0;
            cnt <= '0;
        end else if (accept) begin
            m <= A;
            hi <= '0;
            lo <= B;
            cnt <= '0;
        end else if (state == RUN) begin
            {hi, lo} <= lo[0] ? {cout, s, lo[MUL_W-1:1]} : {1'b0, hi, lo[MUL_W-1:1]};
            cnt <= cnt + 6'd1;
        end
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    assign P = {hi, lo};
endmodule

// File: tb/tb_seq_multiplier32.sv
// tb_seq_multiplier32: randomized scoreboard bench checking products and handshake timing
module tb_seq_multiplier32;
    logic clk = 0, rst, start;
    logic [31:0] A, B;
    logic busy, done;
    logic [63:0] P;
    typedef struct {logic [63:0] p; int acc;} item_t;
    item_t q[$];
    int cyc = 0, n_cmp = 0, n_err = 0, d;
    bit armed = 0;

    seq_multiplier32 dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B),
                          .busy(busy), .done(done), .P(P));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected timing: busy for the 32 cycles after the accepting edge, then one done cycle.
    always @(negedge clk) if (armed) begin
        if (q.size() != 0) begin
            d = cyc - q[0].acc;
            if (d >= 32) begin
                chk("done_at_32", {63'd0, done}, 64'd1);
                chk("busy_at_done", {63'd0, busy}, 64'd0);
                chk("product", P, q[0].p);
                void'(q.pop_front());
            end else begin
                chk("busy_running", {63'd0, busy}, 64'd1);
                chk("done_early", {63'd0, done}, 64'd0);
            end
        end else begin
            chk("idle_done", {63'd0, done}, 64'd0);
            chk("idle_busy", {63'd0, busy}, 64'd0);
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("issue_wait_busy", {63'd0, busy}, 64'd0);
        A = a;
        B = b;
        start = 1;
        @(posedge clk); #1;
        q.push_back('{64'(a) * 64'(b), cyc});
        start = 0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 80) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic reset_now();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_P", P, 64'd0);
    endtask

    initial begin
        rst = 1;
        start = 0;
        A = 0;
        B = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_now();
        armed = 1;
        issue(32'd3, 32'd5);
        drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        issue(32'h8000_0000, 32'd2);
        drain();
        issue(32'd0, 32'hDEAD_BEEF);
        drain();
        // start mid-RUN with new operands must be ignored
        issue(32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        start = 1;
        A = $urandom;
        B = $urandom;
        @(posedge clk); #1;
        start = 0;
        drain();
        // back-to-back with start held through DONE
        issue(32'd7, 32'd9);
        start = 1;
        A = 32'h0001_0000;
        B = 32'h0001_0000;
        for (int t = 0; t < 40 && !done; t++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        q.push_back('{64'h0000_0001_0000_0000, cyc});
        start = 0;
        drain();
        // reset during RUN cycle 20 discards the operation
        issue(32'hCAFE_F00D, 32'h1357_9BDF);
        repeat (19) @(posedge clk);
        #1;
        reset_now();
        repeat (40) @(posedge clk);
        #1;
        issue(32'd6, 32'd7);
        drain();
        for (int i = 0; i < 20; i++) begin
            issue($urandom, $urandom);
            if (i % 3 == 0) drain();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_multiplier32.md
# seq_multiplier32

Unsigned 32×32→64 shift-and-add multiplier built around a single `ripple_adder32` instance. A small FSM sequences the adder over 32 iterations, one per clock. The block sits beside the ALU as the multi-cycle multiply unit and uses a start/busy/done handshake. It reuses the existing adder rather than adding a second carry chain.

## Interface

Parameters:
- None. Width is fixed at 32 by `ripple_adder32`. The iteration count is the package constant `MUL_ITERS` = 32.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start` in 1: request a multiply; only acted on in IDLE or DONE.
- `A` in 32: multiplicand, captured on the accepting edge.
- `B` in 32: multiplier, captured on the accepting edge.
- `busy` out 1: high while an operation is in progress (RUN).
- `done` out 1: one-cycle pulse; `P` is valid in that cycle.
- `P` out 64: product; holds its value until the next accepted `start` or reset.

## Operation

- Registers:
  - `M[31:0]`: latched `A`.
  - `HI[31:0]`: accumulator.
  - `LO[31:0]`: initialised to `B`; its low bits are progressively replaced by product bits.
  - `cnt[5:0]`: iteration counter.
  - `state`.
- Adder hookup: `X`=`HI`, `Y`=`M`, `Cin`=0, outputs `S`, `Cout`.
- States: IDLE, RUN, DONE.
  - IDLE, `start`=1: load `M`←`A`, `HI`←0, `LO`←`B`, `cnt`←0, go to RUN. With `start`=0, stay in IDLE.
  - RUN, each cycle:
    - If `LO[0]`=1: `{HI,LO}` ← `{Cout,S,LO}` >> 1.
    - If `LO[0]`=0: `{HI,LO}` ← `{1'b0,HI,LO}` >> 1.
    - Then `cnt`←`cnt`+1. When `cnt`=31 is being processed, go to DONE.
  - DONE: `done`=1 and `P`=`{HI,LO}`.
    - `start`=1: accept a new operation exactly as from IDLE and go to RUN. This gives back-to-back operation.
    - Otherwise go to IDLE.
- `P` is driven from `{HI,LO}` and is stable in IDLE and DONE. It changes only in RUN. Consumers sample `P` only when `done`=1.
- Arithmetic is unsigned. The 33-bit `{Cout,S}` is never truncated, so no overflow is possible in the 64-bit product.
- Changes on `A`/`B` after the accepting edge have no effect.
- `start` while in RUN is ignored; it is neither queued nor able to abort the operation.

## Timing

- Reset values: state=IDLE, `busy`=0, `done`=0, `P`=0, `HI`=`LO`=`M`=0, `cnt`=0.
- Let edge k accept `start`:
  - `busy`=1 after edge k, through edge k+32.
  - `done`=1 for exactly one cycle, between edges k+32 and k+33.
  - `busy`=0 while `done`=1.
- Latency is 32 cycles from the accepting edge to `done`. Throughput is one product per 33 cycles when `start` is held high in DONE.
- `rst` has priority over everything, including mid-RUN and the DONE cycle. After the reset edge all outputs take their reset values and any in-flight result is discarded.
- `rst` and `start` high on the same edge: reset wins and `start` is dropped.
- Adder path: a full 32-bit ripple sits combinationally between `HI`/`M` and the `HI` register. This is the block's critical path, with no pipelining inside it.

## Structure

- Shared package `mul_pkg` holds:
  - the state enum `mul_state_t` {IDLE, RUN, DONE};
  - `MUL_ITERS` = 32;
  - `MUL_W` = 32.
- One sub-module: the existing `ripple_adder32`, instantiated once, unmodified.
- FSM, counter and shift registers live in `seq_multiplier32` itself.

## Test plan

- Basic product: `A`=3, `B`=5, pulse `start` → `done` exactly 32 cycles later with `P`=0x000000000000000F, `busy` high for 32 cycles.
- Extreme values:
  - `A`=`B`=0xFFFFFFFF → `P`=0xFFFFFFFE00000001 (exercises `Cout`).
  - `A`=0x80000000, `B`=2 → `P`=0x0000000100000000.
- Zero and operand isolation: `A`=0, `B`=0xDEADBEEF → `P`=0. Separately, change `A`/`B` mid-RUN → result still matches the latched operands.
- Ignored start: `start` pulsed at RUN cycle 10 → single `done` at the original time, with the original product.
- Back-to-back: hold `start`=1 with 7×9 then 0x10000×0x10000 → `done` pulses 33 cycles apart with `P`=63, then 0x0000000100000000.
- Reset mid-op: assert `rst` at RUN cycle 20 → next cycle `busy`=0, `done`=0, `P`=0. `done` never pulses for the aborted op. A fresh 6×7 then gives `P`=42.
